// File: rtl/mem_mod_burst.sv
// rtl/mem_mod_burst.sv - single-port memory target with req/gnt handshake, wait states and wrapping bursts
//
// Purpose: CPU-side memory model. The master requests ownership with req and
// issues start-qualified commands while granted. Each beat completes with a
// one-cycle rdy strobe. Bursts wrap from DEPTH-1 to 0.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   req    in   bus ownership request (level)
//   start  in   command strobe, sampled only while granted
//   mode   in   00 single rd, 01 single wr, 10 burst rd, 11 burst wr
//   addr   in   start address, sampled with start
//   wdata  in   write data, sampled on each write beat
//   rdata  out  read data, valid with rdy on read beats, held otherwise
//   gnt    out  ownership granted
//   rdy    out  per-beat completion strobe
//   err    out  one-cycle pulse when a command addresses >= DEPTH
//   avail  out  FSM is idle
module mem_mod_burst #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt,
  output logic              rdy,
  output logic              err,
  output logic              avail
);

  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW = $clog2(WAIT_STATES + 2);
  localparam int BCW = $clog2(BURST_LEN + 2);

  // DEPTH may equal 2**ADDR_W, so the range check needs one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_WAIT, S_XFER} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] xfer_addr;
  logic [WCW-1:0]    wait_cnt;
  logic [BCW-1:0]    beats_left;
  logic              wr_q;
  logic              is_write_eff;
  logic              accept;
  logic              reject;
  logic              last_beat;
  logic              in_range;

  assign in_range  = {1'b0, addr} < DEPTH_X;
  assign last_beat = beats_left == BCW'(1);
  assign addr_inc  = (beat_addr == LAST_ADDR) ? '0 : beat_addr + 1'b1;

  // xfer_addr / is_write_eff describe the beat that will be live in the next
  // cycle, so read data can be registered and presented together with rdy.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    reject       = 1'b0;
    xfer_addr    = beat_addr;
    is_write_eff = wr_q;
    case (state)
      S_IDLE: begin
        if (req) next_state = S_GRANTED;
      end
      S_GRANTED: begin
        if (!req) begin
          next_state = S_IDLE;
        end else if (start) begin
          if (in_range) begin
            accept       = 1'b1;
            next_state   = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
            xfer_addr    = addr;
            is_write_eff = mode[0];
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == WCW'(1)) next_state = S_XFER;
      end
      S_XFER: begin
        if (last_beat) next_state = req ? S_GRANTED : S_IDLE;
        else           xfer_addr  = addr_inc;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 1'b0;
      rdy        <= 1'b0;
      err        <= 1'b0;
      avail      <= 1'b1;
      rdata      <= '0;
      beat_addr  <= '0;
      wait_cnt   <= '0;
      beats_left <= '0;
      wr_q       <= 1'b0;
    end else begin
      gnt   <= next_state != S_IDLE;
      avail <= next_state == S_IDLE;
      rdy   <= next_state == S_XFER;
      err   <= reject;
      if (accept) begin
        beat_addr  <= addr;
        wr_q       <= mode[0];
        wait_cnt   <= WCW'(WAIT_STATES);
        beats_left <= mode[1] ? BCW'(BURST_LEN) : BCW'(1);
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end else if (state == S_XFER && !last_beat) begin
        beat_addr  <= addr_inc;
        beats_left <= beats_left - 1'b1;
      end
      if (next_state == S_XFER && !is_write_eff)
        rdata <= mem[IW'(xfer_addr)];
    end
  end

  // Storage is not reset. The write for the beat whose closing edge samples
  // rst still lands; after that the FSM is idle so nothing else is written.
  always_ff @(posedge clk) begin
    if (state == S_XFER && wr_q)
      mem[IW'(beat_addr)] <= wdata;
  end

endmodule

// File: doc/mem_mod_burst.md
Name: mem_mod_burst

Overview:
Parametrised single-port memory target for the cpu/memory handshake: req/gnt ownership, start-qualified commands, and per-beat rdy completion. It generalises the 8-bit/256-entry memory model as follows:
- configurable data and address width, and configurable depth;
- programmable wait states;
- burst read and burst write modes, with address wrap;
- out-of-range error reporting.
It sits between a CPU-side master and on-chip storage in the test and system tops. The bidirectional data bus is replaced by separate wdata/rdata.

Parameters:
DATA_W, 8, data bus width in bits
ADDR_W, 8, address bus width in bits
DEPTH, 256, number of storage words; must satisfy 1 <= DEPTH <= 2**ADDR_W
WAIT_STATES, 1, idle cycles between command acceptance and first beat (0 allowed)
BURST_LEN, 4, beats per burst command (>= 1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  1  master requests bus ownership (level)
start  input  1  command strobe; sampled only while granted
mode  input  2  00 single read, 01 single write, 10 burst read, 11 burst write
addr  input  ADDR_W  start address, sampled with start
wdata  input  DATA_W  write data; sampled on each write beat (rdy=1)
rdata  output  DATA_W  read data; valid when rdy=1 on read beats
gnt  output  1  ownership granted (level)
rdy  output  1  one-cycle-per-beat completion strobe
err  output  1  one-cycle pulse: command rejected (addr >= DEPTH)
avail  output  1  high when FSM is in IDLE

Behaviour:
- Reset (rst=1 at an edge): FSM -> IDLE; gnt=0, rdy=0, err=0, rdata=0, avail=1; internal counters cleared. Memory contents are not reset. Reset mid-transfer aborts immediately; no further writes occur.
- All outputs are registered. FSM states: IDLE, GRANTED, WAIT, XFER.
- IDLE: gnt=0.
  - req=1 at an edge -> GRANTED; gnt=1 from the next cycle.
  - start is ignored in IDLE.
- GRANTED: gnt=1.
  - req=0 at an edge -> IDLE; a simultaneous start is ignored.
  - req=1 and start=1, with addr >= DEPTH -> err=1 for one cycle; stay GRANTED; no access.
  - req=1 and start=1, with addr in range -> latch mode and addr; beat count = 1 for single modes, BURST_LEN for burst modes. Go to WAIT with counter = WAIT_STATES, or to XFER directly when WAIT_STATES=0.
- WAIT: counter decrements once per cycle. Counter == 1 at an edge -> XFER. The first rdy is high exactly WAIT_STATES+1 cycles after the start-sampling edge.
- XFER: one beat per cycle, back to back, with rdy=1 on every beat cycle.
  - Read beat: rdata = mem[beat_addr] in the same cycle as rdy.
  - Write beat: mem[beat_addr] <= wdata at the edge ending the rdy cycle.
  - beat_addr starts at the latched addr and increments by 1 per beat, wrapping from DEPTH-1 to 0.
  - After the last beat: go to GRANTED if req=1, else IDLE.
- A transfer never aborts on req deassertion. gnt stays 1 until the last beat completes, then follows the rule above.
- start, mode and addr are ignored in WAIT and XFER; commands do not queue.
- rdata holds its last value outside read beats. rdy=0 outside XFER. err and rdy are never high together.
- avail=1 only in IDLE.

Test Plan:
1. Defaults. rst for 2 cycles, then req=1 -> gnt=1 one cycle later. start with mode=01, addr=0x10, wdata=0xA5 -> rdy pulses exactly 2 cycles after the start edge. Then start with mode=00, addr=0x10 -> rdy with rdata=0xA5.
2. Burst write at addr=0xFE, wdata 0x11/0x22/0x33/0x44 on successive beats -> 4 consecutive rdy cycles. Burst read at 0xFE -> rdata 0x11, 0x22, 0x33, 0x44, and mem[0x00]=0x33, mem[0x01]=0x44 (wrap).
3. DEPTH=100. start with addr=100 -> err=1 for one cycle, rdy stays 0, memory unchanged, gnt stays 1. A following command to addr=99 succeeds.
4. Drop req in the cycle after a burst-read start -> all 4 beats still complete, then gnt=0 and avail=1 in the cycle after the last rdy. start=1 together with req=0 in GRANTED -> no transfer.
5. Assert rst during beat 2 of a 4-beat burst write -> outputs reset next cycle. Only beats 1–2 are written; addresses for beats 3–4 keep their old values.
6. WAIT_STATES=0, BURST_LEN=1. Burst read -> rdy in the cycle immediately after the start edge, exactly one beat. start held high during XFER -> no extra command accepted.
